// File: rtl/lm_sm_sequencer.sv
// Decode-stage micro-sequencer: expands LM/SM register masks into one
// single-register transfer micro-op per set bit, stalling fetch until done.
module lm_sm_sequencer #(
  parameter logic [3:0] LM = 4'b0110,
  parameter logic [3:0] SM = 4'b0111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pr1_IR,
  input  logic        in_valid,
  input  logic        hold,
  input  logic        flush,
  output logic [15:0] uop_IR,
  output logic        uop_valid,
  output logic        seq_stall,
  output logic        busy
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e     state_q, state_d;
  logic [7:0] remMask_q, remMask_d;
  logic [2:0] offset_q, offset_d;
  logic [3:0] op_q, op_d;
  logic [2:0] ra_q, ra_d;

  logic [7:0] srcMask;
  logic [7:0] restMask;
  logic [3:0] srcOp;
  logic [2:0] srcRa;
  logic [2:0] srcOff;
  logic [2:0] lowIdx;
  logic       isMulti;
  logic       seqActive;

  // In ISSUE the latched copy is the source; in IDLE the live IF/ID word is.
  always_comb begin
    isMulti   = (pr1_IR[15:12] == LM) || (pr1_IR[15:12] == SM);
    seqActive = (state_q == ISSUE) || (in_valid && isMulti);
    if (state_q == ISSUE) begin
      srcMask = remMask_q;
      srcOp   = op_q;
      srcRa   = ra_q;
      srcOff  = offset_q;
    end else begin
      srcMask = pr1_IR[7:0];
      srcOp   = pr1_IR[15:12];
      srcRa   = pr1_IR[11:9];
      srcOff  = 3'd0;
    end
    lowIdx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (srcMask[i]) lowIdx = 3'(i);
    end
    restMask = srcMask & ~(8'b1 << lowIdx);
  end

  always_comb begin
    uop_IR    = pr1_IR;
    uop_valid = in_valid;
    seq_stall = 1'b0;
    if (seqActive) begin
      uop_IR    = {srcOp, srcRa, lowIdx, srcOff, 3'b000};
      uop_valid = |srcMask;
      seq_stall = |restMask;
    end
    // A redirect kills whatever is in decode, even mid-sequence.
    if (flush) begin
      uop_valid = 1'b0;
      seq_stall = 1'b0;
    end
  end

  assign busy = (state_q == ISSUE);

  always_comb begin
    state_d   = state_q;
    remMask_d = remMask_q;
    offset_d  = offset_q;
    op_d      = op_q;
    ra_d      = ra_q;
    if (flush) begin
      state_d   = IDLE;
      remMask_d = 8'd0;
      offset_d  = 3'd0;
      op_d      = 4'd0;
      ra_d      = 3'd0;
    end else if (!hold) begin
      if (seqActive && (|restMask)) begin
        state_d   = ISSUE;
        remMask_d = restMask;
        offset_d  = srcOff + 3'd1;
        op_d      = srcOp;
        ra_d      = srcRa;
      end else if (seqActive) begin
        state_d   = IDLE;
        remMask_d = 8'd0;
        offset_d  = 3'd0;
        op_d      = 4'd0;
        ra_d      = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      remMask_q <= 8'd0;
      offset_q  <= 3'd0;
      op_q      <= 4'd0;
      ra_q      <= 3'd0;
    end else begin
      state_q   <= state_d;
      remMask_q <= remMask_d;
      offset_q  <= offset_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
    end
  end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Decode-stage micro-sequencer that expands each multi-register LM/SM instruction into one single-register transfer micro-op per set bit of its 8-bit register mask. It sits between the IF/ID pipeline register and the decode/register-read logic. It holds the fetch stage (PC and IF/ID writes) until the last transfer of the current LM/SM has issued. Downstream stages see a plain stream of micro-ops, each carrying its target register and word offset from the base register.

## Interface
Parameters:
- LM, 4'b0110, opcode of load-multiple
- SM, 4'b0111, opcode of store-multiple

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- pr1_IR  input  16  instruction held in IF/ID register; [15:12] opcode, [11:9] RA (base), [7:0] mask (bit i selects Ri)
- in_valid  input  1  pr1_IR holds a real instruction
- hold  input  1  downstream stall; freezes sequencer state
- flush  input  1  control-flow redirect; kills the instruction in decode
- uop_IR  output  16  micro-op to decode
- uop_valid  output  1  uop_IR is a real operation
- seq_stall  output  1  more transfers pending; drives PCWrite low and IF/ID write low
- busy  output  1  state is ISSUE

## Operation
- Micro-op format: [15:12] opcode (LM/SM), [11:9] RA, [8:6] target Ri, [5:3] offset (transfers already issued for this instruction), [2:0] 3'b000.
- Registered state: state {IDLE, ISSUE}, rem_mask[7:0], offset[2:0], latched op[3:0] and RA[2:0]. All reset to zero/IDLE.
- Outputs are combinational from state and inputs.
- IDLE, non-LM/SM or in_valid=0:
  - uop_IR = pr1_IR, uop_valid = in_valid, seq_stall = 0.
- IDLE, in_valid=1, LM/SM, mask=0:
  - uop_valid = 0, seq_stall = 0; instruction retires as a bubble.
- IDLE, in_valid=1, LM/SM, mask≠0:
  - Emit the lowest set bit i of the mask with offset 0.
  - If mask & ~(1<<i) ≠ 0: seq_stall = 1. At the edge, latch op, RA, rem_mask = mask with bit i cleared, offset = 1, and go to ISSUE.
  - Otherwise seq_stall = 0 and stay in IDLE.
- ISSUE:
  - Emit the lowest set bit j of rem_mask with the current offset, uop_valid = 1.
  - If rem_mask has other bits set: seq_stall = 1; at the edge, clear bit j and increment offset.
  - If j is the last bit: seq_stall = 0; at the edge, go to IDLE and clear rem_mask/offset.
- Offset never exceeds 7 (at most 8 transfers), so no wrap.
- Priority at each edge: reset > flush > hold > normal.
  - flush: go to IDLE and clear registers. This cycle uop_valid = 0 and seq_stall = 0, including mid-sequence.
  - hold (no flush): registers unchanged. Outputs keep their combinational values, so seq_stall stays asserted in ISSUE.
- pr1_IR is ignored in ISSUE. The fetch stage is held, so IF/ID keeps the same LM/SM.

## Timing
- Reset values: busy = 0, rem_mask = 0, offset = 0. With in_valid = 0 after reset: uop_valid = 0, seq_stall = 0, uop_IR = pr1_IR.
- Latency: zero-cycle. The first micro-op appears in the same cycle the LM/SM is in IF/ID.
- An instruction with N set mask bits occupies decode for N unheld cycles. seq_stall is high for the first N−1 of them.
- The cycle with seq_stall = 0 is the last transfer. IF/ID loads the next instruction at that edge.
- Each held cycle extends the sequence by one cycle and repeats the identical micro-op.
- Reset mid-sequence: IDLE at the next edge, with no further micro-ops issued.

## Test plan
- LM R2, mask 8'hA5 (pr1_IR = 16'h64A5), in_valid = 1, no hold:
  - uop_IR = 16'h6400, 16'h6488, 16'h6550, 16'h65D8 on four consecutive cycles.
  - seq_stall = 1,1,1,0; busy = 0,1,1,1; then IDLE.
- SM R1, mask 8'h80 (16'h7280):
  - Single cycle, uop_IR = 16'h73C0, uop_valid = 1, seq_stall = 0, busy stays 0.
- LM with mask 8'hFF:
  - Eight micro-ops, Ri = 0..7 with offsets 0..7; seq_stall high for 7 cycles; no offset wrap.
- LM mask 8'h00 (16'h6400 as pr1_IR):
  - uop_valid = 0, seq_stall = 0 for one cycle.
- Mid-sequence events on 16'h64A5:
  - hold asserted during the second micro-op for 2 cycles: 16'h6488 presented 3 cycles with seq_stall = 1; sequence then completes normally.
  - flush during the third micro-op: uop_valid = 0, seq_stall = 0 that cycle; IDLE next cycle.
- reset asserted while busy = 1:
  - Next cycle busy = 0, seq_stall = 0; an ADD (16'h0000) in IF/ID then passes through with uop_valid = 1.
